// File: rtl/fetch_decode.sv
// Single-word Wishbone instruction fetch followed by a one-cycle field decode.
// A request in IDLE launches a read cycle; the returned word is registered,
// announced with o_fetch_done, then split into opcode/operand fields on the
// following edge and announced with o_completed.
module fetch_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [31:0] i_pc,
  output logic [31:0] o_wb_addr,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_instruction,
  output logic        o_fetch_done,
  output logic [3:0]  o_opcode,
  output logic [3:0]  o_extra,
  output logic [3:0]  o_operandA,
  output logic [3:0]  o_operandB,
  output logic [15:0] o_immediate,
  output logic        o_completed
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_ACK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic start_req;
  logic stb_accept;
  logic ack_take;

  // State register; reset aborts any bus cycle in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and bus event decode. An ack is only honoured once the strobe
  // has been accepted (same cycle in STROBE, or later in WAIT_ACK).
  always_comb begin
    state_nxt  = state;
    start_req  = 1'b0;
    stb_accept = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          start_req = 1'b1;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        if (!i_wb_stall) begin
          stb_accept = 1'b1;
          if (i_wb_ack) begin
            ack_take  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (i_wb_ack) begin
          ack_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered Wishbone master outputs and the fetched word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_wb_addr     <= '0;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_instruction <= '0;
      o_fetch_done  <= 1'b0;
    end else begin
      o_fetch_done <= ack_take;
      if (start_req) begin
        o_wb_addr <= i_pc;
        o_wb_cyc  <= 1'b1;
        o_wb_stb  <= 1'b1;
      end
      if (stb_accept) begin
        o_wb_stb <= 1'b0;
      end
      if (ack_take) begin
        o_wb_cyc      <= 1'b0;
        o_instruction <= i_wb_data;
      end
    end
  end

  // Field decode one edge after the word lands; fields hold until next fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_opcode    <= '0;
      o_extra     <= '0;
      o_operandA  <= '0;
      o_operandB  <= '0;
      o_immediate <= '0;
      o_completed <= 1'b0;
    end else begin
      o_completed <= o_fetch_done;
      if (o_fetch_done) begin
        o_opcode    <= o_instruction[31:28];
        o_extra     <= o_instruction[27:24];
        o_operandA  <= o_instruction[23:20];
        o_operandB  <= o_instruction[19:16];
        o_immediate <= o_instruction[15:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: inputs change and outputs are checked on
// the falling clock edge, expected values written out by hand per scenario.
module tb_fetch_decode;

  logic        clk;
  logic        reset;
  logic        i_enable;
  logic [31:0] i_pc;
  logic [31:0] o_wb_addr;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;
  logic [31:0] o_instruction;
  logic        o_fetch_done;
  logic [3:0]  o_opcode;
  logic [3:0]  o_extra;
  logic [3:0]  o_operandA;
  logic [3:0]  o_operandB;
  logic [15:0] o_immediate;
  logic        o_completed;

  int total;
  int bad;
  int acc_cnt;
  int done_cnt;
  int comp_cnt;
  int acc0;
  int done0;
  int comp0;

  fetch_decode dut (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_pc          (i_pc),
    .o_wb_addr     (o_wb_addr),
    .o_wb_cyc      (o_wb_cyc),
    .o_wb_stb      (o_wb_stb),
    .i_wb_ack      (i_wb_ack),
    .i_wb_stall    (i_wb_stall),
    .i_wb_data     (i_wb_data),
    .o_instruction (o_instruction),
    .o_fetch_done  (o_fetch_done),
    .o_opcode      (o_opcode),
    .o_extra       (o_extra),
    .o_operandA    (o_operandA),
    .o_operandB    (o_operandB),
    .o_immediate   (o_immediate),
    .o_completed   (o_completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled with pre-edge values at each rising edge.
  initial begin
    acc_cnt  = 0;
    done_cnt = 0;
    comp_cnt = 0;
  end
  always @(posedge clk) begin
    if (reset && o_wb_stb && !i_wb_stall) acc_cnt++;
    if (o_fetch_done) done_cnt++;
    if (o_completed)  comp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_fields(input string tag, input logic [3:0] op, input logic [3:0] ex,
                              input logic [3:0] a, input logic [3:0] b, input logic [15:0] imm);
    check({tag, "_opcode"}, {28'd0, o_opcode},   {28'd0, op});
    check({tag, "_extra"},  {28'd0, o_extra},    {28'd0, ex});
    check({tag, "_opA"},    {28'd0, o_operandA}, {28'd0, a});
    check({tag, "_opB"},    {28'd0, o_operandB}, {28'd0, b});
    check({tag, "_imm"},    {16'd0, o_immediate},{16'd0, imm});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    i_enable   = 1'b0;
    i_pc       = '0;
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_data  = '0;

    // Reset state
    step();
    check("rst_cyc",  {31'd0, o_wb_cyc}, 32'd0);
    check("rst_stb",  {31'd0, o_wb_stb}, 32'd0);
    check("rst_addr", o_wb_addr, 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_done", {31'd0, o_fetch_done}, 32'd0);
    check("rst_comp", {31'd0, o_completed}, 32'd0);
    check_fields("rst", 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    reset = 1'b1;
    step();

    // Zero-wait fetch; also a stray ack while idle must be ignored
    i_wb_ack = 1'b1;
    i_wb_data = 32'hDEADBEEF;
    step();
    check("idle_ack_done", {31'd0, o_fetch_done}, 32'd0);
    check("idle_ack_cyc",  {31'd0, o_wb_cyc}, 32'd0);
    i_wb_ack = 1'b0;
    i_pc     = 32'hB000_0000;
    i_enable = 1'b1;
    step();
    i_enable = 1'b0;
    check("zw_cyc",  {31'd0, o_wb_cyc}, 32'd1);
    check("zw_stb",  {31'd0, o_wb_stb}, 32'd1);
    check("zw_addr", o_wb_addr, 32'hB000_0000);
    step();
    check("zw_stb_drop", {31'd0, o_wb_stb}, 32'd0);
    check("zw_cyc_hold", {31'd0, o_wb_cyc}, 32'd1);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h1234_ABCD;
    step();
    i_wb_ack = 1'b0;
    check("zw_done",  {31'd0, o_fetch_done}, 32'd1);
    check("zw_instr", o_instruction, 32'h1234_ABCD);
    check("zw_cyc_end", {31'd0, o_wb_cyc}, 32'd0);
    check("zw_comp_early", {31'd0, o_completed}, 32'd0);
    step();
    check("zw_done_pulse", {31'd0, o_fetch_done}, 32'd0);
    check("zw_comp", {31'd0, o_completed}, 32'd1);
    check_fields("zw", 4'h1, 4'h2, 4'h3, 4'h4, 16'hABCD);
    step();
    check("zw_comp_pulse", {31'd0, o_completed}, 32'd0);
    check_fields("zw_hold", 4'h1, 4'h2, 4'h3, 4'h4, 16'hABCD);

    // Stall for 3 cycles, then accept with same-cycle ack
    acc0 = acc_cnt; done0 = done_cnt;
    i_pc       = 32'hB000_0008;
    i_enable   = 1'b1;
    i_wb_stall = 1'b1;
    step();
    i_enable = 1'b0;
    i_pc     = 32'h0000_0000;
    check("st_stb0", {31'd0, o_wb_stb}, 32'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check("st_stb_hold",  {31'd0, o_wb_stb}, 32'd1);
      check("st_addr_hold", o_wb_addr, 32'hB000_0008);
    end
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b1;
    i_wb_data  = 32'hA500_0001;
    step();
    i_wb_ack = 1'b0;
    check("st_done",  {31'd0, o_fetch_done}, 32'd1);
    check("st_instr", o_instruction, 32'hA500_0001);
    check("st_stb_end", {31'd0, o_wb_stb}, 32'd0);
    step();
    step();
    check("st_accepts", acc_cnt - acc0, 32'd1);
    check("st_dones",   done_cnt - done0, 32'd1);
    check_fields("st", 4'hA, 4'h5, 4'h0, 4'h0, 16'h0001);

    // Slow ack (5 cycles after acceptance) with a busy enable in WAIT_ACK
    i_pc     = 32'hB000_0000;
    i_enable = 1'b1;
    step();
    i_enable = 1'b0;
    step();
    check("sa_stb_low", {31'd0, o_wb_stb}, 32'd0);
    i_pc     = 32'hB000_0004;
    i_enable = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      i_enable = 1'b0;
      check("sa_cyc_hold", {31'd0, o_wb_cyc}, 32'd1);
      check("sa_stb_low",  {31'd0, o_wb_stb}, 32'd0);
      check("sa_addr_busy", o_wb_addr, 32'hB000_0000);
    end
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h3F8C_0010;
    step();
    i_wb_ack = 1'b0;
    check("sa_done",  {31'd0, o_fetch_done}, 32'd1);
    check("sa_instr", o_instruction, 32'h3F8C_0010);
    step();
    check("sa_comp", {31'd0, o_completed}, 32'd1);
    check_fields("sa", 4'h3, 4'hF, 4'h8, 4'hC, 16'h0010);
    step();
    check("sa_no_refetch", {31'd0, o_wb_cyc}, 32'd0);

    // Reset mid-fetch, then a late ack after release
    done0 = done_cnt; comp0 = comp_cnt;
    i_pc     = 32'hB000_000C;
    i_enable = 1'b1;
    step();
    i_enable = 1'b0;
    check("rm_cyc_before", {31'd0, o_wb_cyc}, 32'd1);
    reset = 1'b0;
    #1;
    check("rm_cyc",   {31'd0, o_wb_cyc}, 32'd0);
    check("rm_stb",   {31'd0, o_wb_stb}, 32'd0);
    check("rm_addr",  o_wb_addr, 32'd0);
    check("rm_instr", o_instruction, 32'd0);
    check_fields("rm", 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    step();
    reset     = 1'b1;
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h7777_7777;
    step();
    step();
    i_wb_ack = 1'b0;
    step();
    step();
    check("rm_no_done", done_cnt - done0, 32'd0);
    check("rm_no_comp", comp_cnt - comp0, 32'd0);
    check("rm_instr_after", o_instruction, 32'd0);

    // Back-to-back fetches, second enable on the o_fetch_done cycle
    i_pc     = 32'hB000_0000;
    i_enable = 1'b1;
    step();
    i_enable  = 1'b0;
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h1234_5678;
    step();
    i_wb_ack = 1'b0;
    check("bb_done1",  {31'd0, o_fetch_done}, 32'd1);
    check("bb_instr1", o_instruction, 32'h1234_5678);
    i_pc     = 32'hB000_0004;
    i_enable = 1'b1;
    step();
    i_enable = 1'b0;
    check("bb_cyc2",  {31'd0, o_wb_cyc}, 32'd1);
    check("bb_stb2",  {31'd0, o_wb_stb}, 32'd1);
    check("bb_addr2", o_wb_addr, 32'hB000_0004);
    check("bb_comp1", {31'd0, o_completed}, 32'd1);
    check_fields("bb1", 4'h1, 4'h2, 4'h3, 4'h4, 16'h5678);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h9ABC_DEF0;
    step();
    i_wb_ack = 1'b0;
    check("bb_done2",  {31'd0, o_fetch_done}, 32'd1);
    check("bb_instr2", o_instruction, 32'h9ABC_DEF0);
    step();
    check("bb_comp2", {31'd0, o_completed}, 32'd1);
    check_fields("bb2", 4'h9, 4'hA, 4'hB, 4'hC, 16'hDEF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
